// File: rtl/qpsk_modem.sv
// QPSK modem pair: Gray-mapped modulator and hard-decision sign-slicing demodulator.
// Both halves share only clock and reset; each output is registered with one cycle latency.

module qpsk_modulator #(
  parameter logic signed [15:0] AMP = 16'sd23170
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         data_i,
  output logic signed [15:0] data_o_i,
  output logic signed [15:0] data_o_q
);

  logic signed [15:0] amp_neg;

  // AMP is limited to 1..32767, so the negation cannot overflow
  assign amp_neg = -AMP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o_i <= '0;
      data_o_q <= '0;
    end else begin
      data_o_i <= data_i[1] ? amp_neg : AMP;
      data_o_q <= data_i[0] ? amp_neg : AMP;
    end
  end

endmodule

module qpsk_demodulator (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] data_i_i,
  input  logic signed [15:0] data_i_q,
  output logic [1:0]         data_o
);

  // Sign bit is the decision: zero slices to 0, -32768 slices to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o <= 2'b00;
    end else begin
      data_o <= {data_i_i[15], data_i_q[15]};
    end
  end

endmodule

module qpsk_modem #(
  parameter logic signed [15:0] AMP = 16'sd23170
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         data_i,
  output logic signed [15:0] data_o_i,
  output logic signed [15:0] data_o_q,
  input  logic signed [15:0] data_i_i,
  input  logic signed [15:0] data_i_q,
  output logic [1:0]         data_o
);

  qpsk_modulator #(
    .AMP (AMP)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .data_o_i (data_o_i),
    .data_o_q (data_o_q)
  );

  qpsk_demodulator u_demod (
    .clk      (clk),
    .rst      (rst),
    .data_i_i (data_i_i),
    .data_i_q (data_i_q),
    .data_o   (data_o)
  );

endmodule

// File: tb/tb_qpsk_modem.sv
// Bench for qpsk_modem: default-AMP instance with switchable loopback plus an AMP=1
// instance permanently looped back, both checked against a symbol-level model.

module tb_qpsk_modem;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         data_i;
  logic               lb;
  logic signed [15:0] drv_i, drv_q, din_i, din_q;
  logic signed [15:0] mo_i, mo_q, m1_i, m1_q;
  logic [1:0]         dmo, d1o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign din_i = lb ? mo_i : drv_i;
  assign din_q = lb ? mo_q : drv_q;

  qpsk_modem u_dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .data_o_i (mo_i),
    .data_o_q (mo_q),
    .data_i_i (din_i),
    .data_i_q (din_q),
    .data_o   (dmo)
  );

  qpsk_modem #(
    .AMP (16'sd1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .data_o_i (m1_i),
    .data_o_q (m1_q),
    .data_i_i (m1_i),
    .data_i_q (m1_q),
    .data_o   (d1o)
  );

  // Symbol-level model: expected outputs plus a history of applied symbols
  int         e_i, e_q, e1_i, e1_q;
  logic [1:0] e_d, e1_d, h1, h2;
  logic       lbh1;
  int         nedge;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_i <= 0; e_q <= 0; e1_i <= 0; e1_q <= 0;
      e_d <= 2'b00; e1_d <= 2'b00;
      h1 <= 2'b00; h2 <= 2'b00; lbh1 <= 1'b0; nedge <= 0;
    end else begin
      e_i  <= data_i[1] ? -23170 : 23170;
      e_q  <= data_i[0] ? -23170 : 23170;
      e1_i <= data_i[1] ? -1 : 1;
      e1_q <= data_i[0] ? -1 : 1;
      e_d  <= {(din_i < 0), (din_q < 0)};
      e1_d <= {(m1_i < 0), (m1_q < 0)};
      h1   <= data_i;
      h2   <= h1;
      lbh1 <= lb;
      if (nedge < 3) nedge <= nedge + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    chk("mod_i", int'(mo_i), e_i);
    chk("mod_q", int'(mo_q), e_q);
    chk("demod", int'(dmo), int'(e_d));
    chk("amp1_mod_i", int'(m1_i), e1_i);
    chk("amp1_mod_q", int'(m1_q), e1_q);
    chk("amp1_demod", int'(d1o), int'(e1_d));
    if (lbh1 && nedge >= 2) chk("loop_delay", int'(dmo), int'(h2));
    if (nedge >= 2) chk("amp1_loop_delay", int'(d1o), int'(h2));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
  endtask

  int mp_i[4] = '{23170, 23170, -23170, -23170};
  int mp_q[4] = '{23170, -23170, 23170, -23170};
  int sl_i[4] = '{0, -1, 32767, -32768};
  int sl_q[4] = '{0, 1, -32768, -1};
  int sl_d[4] = '{0, 2, 1, 3};
  logic [1023:0] pat;
  logic [31:0]   lfsr;

  initial begin
    rst = 1'b1; lb = 1'b0; data_i = 2'b11; drv_i = -16'sd5; drv_q = -16'sd5;
    #1 rst = 1'b0;

    // Reset held: outputs stay at zero despite active inputs
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_mod_i", int'(mo_i), 0);
      chk("rst_mod_q", int'(mo_q), 0);
      chk("rst_demod", int'(dmo), 0);
    end
    rst = 1'b1;
    tick();
    chk("first_mod_i", int'(mo_i), -23170);
    chk("first_mod_q", int'(mo_q), -23170);
    chk("first_demod", int'(dmo), 3);
    chk("first_amp1_i", int'(m1_i), -1);

    // Mapping sweep
    for (int k = 0; k < 4; k++) begin
      data_i = 2'(k);
      tick();
      chk("map_i", int'(mo_i), mp_i[k]);
      chk("map_q", int'(mo_q), mp_q[k]);
    end

    // Slicer boundary values
    for (int k = 0; k < 4; k++) begin
      drv_i = 16'(sl_i[k]);
      drv_q = 16'(sl_q[k]);
      tick();
      chk("slice", int'(dmo), sl_d[k]);
    end

    // Loopback stream, two bits per clock, LSB first
    lfsr = 32'hACE1_2345;
    for (int i = 0; i < 1024; i++) begin
      pat[i] = lfsr[0];
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
    lb = 1'b1;
    for (int k = 0; k < 512; k++) begin
      data_i = pat[2*k +: 2];
      tick();
    end
    tick();
    tick();

    // Asynchronous reset between edges during loopback
    data_i = 2'b11;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_mod_i", int'(mo_i), 0);
    chk("async_mod_q", int'(mo_q), 0);
    chk("async_demod", int'(dmo), 0);
    chk("async_amp1_demod", int'(d1o), 0);
    tick();
    rst = 1'b1;
    data_i = 2'b10;
    tick();
    data_i = 2'b01;
    tick();
    chk("resume_demod", int'(dmo), 2);
    chk("resume_amp1_demod", int'(d1o), 2);
    tick();
    chk("resume_demod2", int'(dmo), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
